// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg -- shared definitions for the instruction fetch unit.
//
// Holds the reset fetch address, the default instruction buffer depth, the
// buffer entry type and a small PC increment helper used by both the fetch
// and response PC registers.
package ifetch_unit_pkg;

  localparam logic [31:0] IFETCH_RESET_PC = 32'hBFC0_0000;
  localparam int          IFETCH_DEPTH    = 4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  // Sequential next address; wraps at 2^32 with no overflow indication.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- DEPTH-entry synchronous FIFO holding fetched instructions.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (empties the FIFO)
//   push       write pushEntry at the tail (ignored when full)
//   pushEntry  entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      empty the FIFO; overrides push and pop in the same cycle
//   headEntry  current head entry, combinational from storage
//   count      number of valid entries (0..DEPTH)
//   empty      count == 0
//
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module ifetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = IFETCH_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetchEntry_t                    pushEntry,
  input  logic                           pop,
  input  logic                           flush,
  output fetchEntry_t                    headEntry,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fetchEntry_t     mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic            doPush;
  logic            doPop;

  assign doPush = push && (count != CW'(DEPTH));
  assign doPop  = pop && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushEntry;
  end

  assign headEntry = mem[rdPtr];
  assign empty     = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end with an in-order bus and a
// small instruction buffer toward decode.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   redirect_valid/_pc        branch/jump redirect from decode (highest priority)
//   out_valid/out_ready       instruction hand-off to decode
//   out_instr/out_pc/out_pcplus4  head instruction, its address, address+4
//   inst_req/inst_addr        bus request and word address
//   inst_addr_ok              bus accepted the request this cycle
//   inst_data_ok/inst_rdata   in-order response from the bus
//
// Handshakes: a transfer happens in a cycle where the producer's valid
// (out_valid, inst_req) and the consumer's ready (out_ready, inst_addr_ok)
// are both high at the rising edge; the producer may not depend on ready to
// raise valid, and payload may change while not yet accepted.
//
// Flow control: a request is only issued while buffered entries plus
// outstanding requests leave room, so every response always has a slot.
// After a redirect, responses to requests issued before it (including one
// accepted in the redirect cycle itself) are counted in discardCnt and
// dropped as they arrive.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
  parameter int          DEPTH    = IFETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam int            CW        = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(DEPTH);

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [CW-1:0] inflightCnt;
  logic [CW-1:0] discardCnt;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflightNext;
  logic [CW:0]   outstanding;
  logic          fifoEmpty;
  logic          accept;
  logic          respValid;
  logic          pushEn;
  logic          popEn;
  fetchEntry_t   pushEntry;
  fetchEntry_t   headEntry;

  assign outstanding = {1'b0, occupancy} + {1'b0, inflightCnt};

  // Gated by rst so no request is presented while reset is held.
  assign inst_req  = rst && (outstanding < DEPTH_LIM);
  assign inst_addr = {fetchPc[31:2], 2'b00};
  assign accept    = inst_req && inst_addr_ok;

  // A response with nothing outstanding is a bus protocol error; ignoring
  // it keeps the counters from wrapping.
  assign respValid    = inst_data_ok && (inflightCnt != '0);
  assign inflightNext = inflightCnt + CW'(accept) - CW'(respValid);

  // Redirect wins over push and pop; the FIFO flush wins inside the FIFO too.
  assign pushEn = respValid && (discardCnt == '0) && !redirect_valid;
  assign popEn  = out_valid && out_ready && !redirect_valid;

  assign pushEntry.pc    = respPc;
  assign pushEntry.instr = inst_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      inflightCnt <= '0;
      discardCnt  <= '0;
    end else begin
      inflightCnt <= inflightNext;
      if (redirect_valid) begin
        fetchPc    <= redirect_pc;
        respPc     <= redirect_pc;
        // Everything still on the bus after this edge belongs to the old path.
        discardCnt <= inflightNext;
      end else begin
        if (accept) fetchPc <= nextPc(fetchPc);
        if (respValid) begin
          if (discardCnt != '0) discardCnt <= discardCnt - CW'(1);
          else                  respPc     <= nextPc(respPc);
        end
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pushEn),
    .pushEntry (pushEntry),
    .pop       (popEn),
    .flush     (redirect_valid),
    .headEntry (headEntry),
    .count     (occupancy),
    .empty     (fifoEmpty)
  );

  assign out_valid   = !fifoEmpty;
  assign out_instr   = headEntry.instr;
  assign out_pc      = headEntry.pc;
  assign out_pcplus4 = nextPc(headEntry.pc);

endmodule
